// File: rtl/operand_fetch_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_wb_pkg
// Description : Shared constants for the operand-fetch / write-back stage:
//               default register address width, register count and the bit
//               positions of the status flags inside o_status.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_wb_pkg;

  localparam int REG_ADDR_DEFAULT = 4;
  localparam int NUM_REGS         = 2 ** REG_ADDR_DEFAULT;

  // Status register bit positions, o_status = {V,C,N,Z}
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

endpackage : operand_fetch_wb_pkg
`default_nettype wire

// File: rtl/operand_fetch_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_wb_regfile
// Description : 2**REG_ADDR x WIDTH register file, one write port and two
//               combinational read ports. Entry 0 reads as zero and ignores
//               writes. No read-during-write bypass here; the top adds it.
// Ports       : clk, rst_n            - clock, async active-low reset
//               we, waddr, wdata      - write port
//               raddr_a / rdata_a     - read port A
//               raddr_b / rdata_b     - read port B
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_wb_regfile
  import operand_fetch_wb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = REG_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [REG_ADDR-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [REG_ADDR-1:0] raddr_a,
  output logic [WIDTH-1:0]    rdata_a,
  input  logic [REG_ADDR-1:0] raddr_b,
  output logic [WIDTH-1:0]    rdata_b
);

  localparam int NUM = 2 ** REG_ADDR;

  logic [WIDTH-1:0] mem [NUM];

  // Entry 0 is never written, so it stays at its reset value; the read
  // muxes still force zero so R0 does not depend on that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule : operand_fetch_wb_regfile
`default_nettype wire

// File: rtl/operand_fetch_wb.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_wb
// Description : Operand fetch and write-back stage in front of the function
//               unit. Reads two source registers (with write-through bypass),
//               optionally replaces operand B with an immediate, registers
//               both operands, writes ALU/memory data back and holds the
//               Z/N/C/V status register.
// Ports       : i_clk, i_rst_n                 - clock, async active-low reset
//               i_valid, i_aa, i_ba, i_mb,
//               i_const                         - fetch request
//               o_opr_a, o_opr_b, o_opr_valid   - registered operands
//               i_rw, i_da, i_md, i_func,
//               i_data_in                       - write-back port
//               i_fl, i_z, i_n, i_c, i_v        - status load and flags
//               o_status                        - {V,C,N,Z}
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_wb
  import operand_fetch_wb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = REG_ADDR_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [REG_ADDR-1:0] i_aa,
  input  logic [REG_ADDR-1:0] i_ba,
  input  logic                i_mb,
  input  logic [WIDTH-1:0]    i_const,
  output logic [WIDTH-1:0]    o_opr_a,
  output logic [WIDTH-1:0]    o_opr_b,
  output logic                o_opr_valid,
  input  logic                i_rw,
  input  logic [REG_ADDR-1:0] i_da,
  input  logic                i_md,
  input  logic [WIDTH-1:0]    i_func,
  input  logic [WIDTH-1:0]    i_data_in,
  input  logic                i_fl,
  input  logic                i_z,
  input  logic                i_n,
  input  logic                i_c,
  input  logic                i_v,
  output logic [3:0]          o_status
);

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             byp_a;
  logic             byp_b;
  logic [3:0]       status_next;

  assign wd = i_md ? i_data_in : i_func;

  operand_fetch_wb_regfile #(
    .WIDTH    (WIDTH),
    .REG_ADDR (REG_ADDR)
  ) regfile (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .we      (i_rw),
    .waddr   (i_da),
    .wdata   (wd),
    .raddr_a (i_aa),
    .rdata_a (rf_a),
    .raddr_b (i_ba),
    .rdata_b (rf_b)
  );

  // Same-edge write and read of one register: forward the write data.
  // Address 0 is excluded so R0 stays zero even while being "written".
  assign byp_a = i_rw && (i_da == i_aa) && (i_aa != '0);
  assign byp_b = i_rw && (i_da == i_ba) && (i_ba != '0);
  assign rd_a  = byp_a ? wd : rf_a;
  assign rd_b  = byp_b ? wd : rf_b;

  always_comb begin
    status_next       = '0;
    status_next[ST_Z] = i_z;
    status_next[ST_N] = i_n;
    status_next[ST_C] = i_c;
    status_next[ST_V] = i_v;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_opr_a     <= '0;
      o_opr_b     <= '0;
      o_opr_valid <= 1'b0;
      o_status    <= 4'b0000;
    end else begin
      o_opr_valid <= i_valid;
      if (i_valid) begin
        o_opr_a <= rd_a;
        o_opr_b <= i_mb ? i_const : rd_b;
      end
      if (i_fl) begin
        o_status <= status_next;
      end
    end
  end

endmodule : operand_fetch_wb
`default_nettype wire

// File: tb/tb_operand_fetch_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_wb
// Description : Directed self-checking bench for operand_fetch_wb. Expected
//               operands are queued when a fetch is issued and compared when
//               o_opr_valid reports them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_wb;

  localparam int WIDTH    = 32;
  localparam int REG_ADDR = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid;
  logic [REG_ADDR-1:0] aa, ba, da;
  logic                mb, rw, md, fl, z, n, c, v;
  logic [WIDTH-1:0]    cnst, func, data_in;
  logic [WIDTH-1:0]    opr_a, opr_b;
  logic                opr_valid;
  logic [3:0]          status;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  operand_fetch_wb #(
    .WIDTH    (WIDTH),
    .REG_ADDR (REG_ADDR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_aa        (aa),
    .i_ba        (ba),
    .i_mb        (mb),
    .i_const     (cnst),
    .o_opr_a     (opr_a),
    .o_opr_b     (opr_b),
    .o_opr_valid (opr_valid),
    .i_rw        (rw),
    .i_da        (da),
    .i_md        (md),
    .i_func      (func),
    .i_data_in   (data_in),
    .i_fl        (fl),
    .i_z         (z),
    .i_n         (n),
    .i_c         (c),
    .i_v         (v),
    .o_status    (status)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid = 0; aa = '0; ba = '0; mb = 0; cnst = '0;
    rw = 0; da = '0; md = 0; func = '0; data_in = '0;
    fl = 0; z = 0; n = 0; c = 0; v = 0;
  endtask

  task automatic fetch(input logic [REG_ADDR-1:0] a_addr,
                       input logic [REG_ADDR-1:0] b_addr,
                       input logic use_imm, input logic [WIDTH-1:0] imm,
                       input logic [WIDTH-1:0] exp_a,
                       input logic [WIDTH-1:0] exp_b, input string tag);
    exp_t e;
    valid = 1; aa = a_addr; ba = b_addr; mb = use_imm; cnst = imm;
    e.a = exp_a; e.b = exp_b; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic write(input logic [REG_ADDR-1:0] addr, input logic sel_mem,
                       input logic [WIDTH-1:0] value);
    rw = 1; da = addr; md = sel_mem;
    if (sel_mem) data_in = value; else func = value;
  endtask

  // Clock one edge, then check valid against the scoreboard and compare
  // any operands the DUT presents. Inputs return to idle afterwards.
  task automatic tick(input string tag);
    exp_t e;
    logic exp_valid;
    exp_valid = valid;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {{(WIDTH-1){1'b0}}, opr_valid},
          {{(WIDTH-1){1'b0}}, exp_valid});
    if (opr_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, ".unexpected"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, ".a"}, opr_a, e.a);
        check({e.tag, ".b"}, opr_b, e.b);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.a", opr_a, '0);
    check("rst.b", opr_b, '0);
    check("rst.status", {28'd0, status}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;

    // Write then read from the array
    write(4'd3, 1'b0, 32'h1234_5678);                 tick("wr3");
    fetch(4'd3, 4'd3, 1'b0, '0, 32'h1234_5678, 32'h1234_5678, "rd3"); tick("rd3");

    // Bypass on operand A, array read on operand B
    write(4'd2, 1'b0, 32'h0000_0011);                 tick("wr2");
    write(4'd7, 1'b1, 32'hA5A5_A5A5);
    fetch(4'd7, 4'd2, 1'b0, '0, 32'hA5A5_A5A5, 32'h0000_0011, "byp_a"); tick("byp_a");
    fetch(4'd2, 4'd7, 1'b0, '0, 32'h0000_0011, 32'hA5A5_A5A5, "arr7"); tick("arr7");
    // Bypass on operand B
    write(4'd8, 1'b0, 32'h0BAD_F00D);
    fetch(4'd0, 4'd8, 1'b0, '0, 32'h0, 32'h0BAD_F00D, "byp_b"); tick("byp_b");

    // R0 ignores writes (both later and same-edge), immediate select
    write(4'd0, 1'b0, 32'hFFFF_FFFF);                 tick("wr0");
    write(4'd0, 1'b0, 32'hFFFF_FFFF);
    fetch(4'd0, 4'd0, 1'b1, 32'h0000_002A, 32'h0, 32'h0000_002A, "r0_imm"); tick("r0_imm");
    fetch(4'd0, 4'd0, 1'b0, '0, 32'h0, 32'h0, "r0_both"); tick("r0_both");

    // Same-edge write to k with immediate on B
    write(4'd4, 1'b0, 32'h0000_0044);
    fetch(4'd4, 4'd4, 1'b1, 32'h0000_0099, 32'h0000_0044, 32'h0000_0099, "wr_imm"); tick("wr_imm");

    // Hold with i_valid=0 while the source register is rewritten
    write(4'd1, 1'b0, 32'h0000_0055);                 tick("wr1");
    fetch(4'd1, 4'd0, 1'b0, '0, 32'h0000_0055, 32'h0, "rd1"); tick("rd1");
    write(4'd1, 1'b0, 32'h0000_0066);                 tick("hold1");
    check("hold1.a", opr_a, 32'h0000_0055);
    write(4'd1, 1'b0, 32'h0000_0066);                 tick("hold2");
    check("hold2.a", opr_a, 32'h0000_0055);
    fetch(4'd1, 4'd1, 1'b0, '0, 32'h0000_0066, 32'h0000_0066, "rd1_new"); tick("rd1_new");

    // Status load and hold
    fl = 1; z = 1; n = 0; c = 1; v = 0;               tick("st_load");
    check("st_load", {28'd0, status}, 32'h5);
    fl = 0; z = 0; n = 1; c = 0; v = 1;               tick("st_hold");
    check("st_hold", {28'd0, status}, 32'h5);
    fl = 1; z = 0; n = 1; c = 0; v = 1;               tick("st_load2");
    check("st_load2", {28'd0, status}, 32'hA);

    // Mid-run reset clears everything and aborts a pending write
    write(4'd5, 1'b0, 32'hDEAD_BEEF);                 tick("wr5");
    fetch(4'd5, 4'd5, 1'b0, '0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd5"); tick("rd5");
    write(4'd6, 1'b0, 32'h0000_0666);
    fetch(4'd5, 4'd5, 1'b0, '0, 32'h0, 32'h0, "unused");
    #2;
    rst_n = 0;
    exp_q.pop_back();
    #1;
    check("arst.a", opr_a, '0);
    check("arst.b", opr_b, '0);
    check("arst.valid", {31'd0, opr_valid}, 32'd0);
    check("arst.status", {28'd0, status}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst_n = 1;
    #1;
    fetch(4'd5, 4'd6, 1'b0, '0, 32'h0, 32'h0, "post_rst"); tick("post_rst");
    check("post_rst.status", {28'd0, status}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_operand_fetch_wb
`default_nettype wire
